drive_sequencer: RTL and testbench

Drive-path controller for the rover's two H-bridge channels. It arbitrates between three motion requesters: the overcurrent fault from the current-sense circuit, the inductive metal detector, and the beacon-tracking steering command. It sequences direction changes through an enforced dead/brake interval. It owns the IN1–IN4 direction lines and the left/right PWM generators, replacing ad-hoc direct drive of those pins by the sensor blocks.

---
 rtl/drive_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_drive_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Drive-path sequencer: arbitrates fault / metal / steering requests, enforces a dead interval
// before direction changes and drives the H-bridge lines and PWM. Optional ramp: SOFTSTART_EN.
module drive_sequencer #(
  parameter int unsigned       DUTY_W        = 8,
  parameter int unsigned       DEAD_CYCLES   = 50000,
  parameter int unsigned       ROTATE_CYCLES = 25000000,
  parameter logic [DUTY_W-1:0] ROT_DUTY      = 8'd160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fault_l,
  input  logic              fault_r,
  input  logic              clear,
  input  logic              metal_det,
  input  logic [1:0]        track_req,
  input  logic [DUTY_W-1:0] track_duty,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              in4,
  output logic [2:0]        state,
  output logic              busy
);

  localparam int unsigned DwellMax = (ROTATE_CYCLES > DEAD_CYCLES) ? ROTATE_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW     = (DwellMax > 1) ? $clog2(DwellMax) : 1;
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [CntW-1:0] RotLast  = CntW'(ROTATE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDead   = 3'd1,
    StRun    = 3'd2,
    StRotate = 3'd3,
    StFault  = 3'd4
  } state_e;

  localparam logic [1:0] ReqStop  = 2'b00;
  localparam logic [1:0] ReqFwd   = 2'b01;
  localparam logic [1:0] ReqLeft  = 2'b10;
  localparam logic [1:0] ReqRight = 2'b11;

  state_e            state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        tgt_q, tgt_d;
  logic              tgt_rot_q, tgt_rot_d;
  logic [CntW-1:0]   dwell_q, dwell_d;
  logic              metal_prev_q;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic [3:0]        in_q, in_d;
  logic              busy_q, busy_d;

  logic              fault_any;
  logic              metal_edge;
  logic              active_d;
  logic              wrap;
  logic [DUTY_W-1:0] src_duty;

  assign fault_any  = fault_l | fault_r;
  assign metal_edge = metal_det & ~metal_prev_q;

  // Next-state logic; priority is fault, then metal edge, then the steering request.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    tgt_d     = tgt_q;
    tgt_rot_d = tgt_rot_q;
    if (fault_any) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (metal_edge) begin
            state_d   = StDead;
            tgt_rot_d = 1'b1;
          end else if (track_req != ReqStop) begin
            state_d   = StDead;
            tgt_rot_d = 1'b0;
            tgt_d     = track_req;
          end
        end
        StDead: begin
          // Retargeting keeps the dwell count running.
          if (metal_edge) begin
            tgt_rot_d = 1'b1;
          end else if (!tgt_rot_q) begin
            tgt_d = track_req;
          end
          if (!tgt_rot_d && (track_req == ReqStop)) begin
            state_d = StIdle;
          end else if (dwell_q == DeadLast) begin
            if (tgt_rot_d) begin
              state_d = StRotate;
            end else begin
              state_d = StRun;
              dir_d   = tgt_d;
            end
          end
        end
        StRun: begin
          if (metal_edge) begin
            state_d   = StDead;
            tgt_rot_d = 1'b1;
          end else if (track_req == ReqStop) begin
            state_d = StIdle;
          end else if (track_req != dir_q) begin
            state_d   = StDead;
            tgt_rot_d = 1'b0;
            tgt_d     = track_req;
          end
        end
        StRotate: begin
          if (dwell_q == RotLast) begin
            state_d = StIdle;
          end
        end
        StFault: begin
          if (clear) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Dwell counter only runs while staying in a timed state; any state change restarts it.
  always_comb begin
    dwell_d = '0;
    if ((state_d == state_q) && ((state_q == StDead) || (state_q == StRotate))) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // Registered outputs are computed from the next state so they change with the state code.
  always_comb begin
    in_d = 4'b0000;
    unique case (state_d)
      StRun: begin
        unique case (dir_d)
          ReqFwd:   in_d = 4'b1010;
          ReqLeft:  in_d = 4'b0110;
          ReqRight: in_d = 4'b1001;
          default:  in_d = 4'b0000;
        endcase
      end
      StRotate: in_d = 4'b1001;
      default:  in_d = 4'b0000;
    endcase
    busy_d = (state_d == StDead) || (state_d == StRotate);
  end

  always_comb begin
    active_d  = (state_d == StRun) || (state_d == StRotate);
    wrap      = &pwm_cnt_q;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    src_duty  = '0;
    if (state_d == StRun) begin
      src_duty = track_duty;
    end else if (state_d == StRotate) begin
      src_duty = ROT_DUTY;
    end
    duty_d = duty_q;
`ifdef SOFTSTART_EN
    if (active_d && (state_d != state_q)) begin
      duty_d = '0;
    end else if (wrap) begin
      if (src_duty < duty_q) begin
        duty_d = src_duty;
      end else if (duty_q < src_duty) begin
        duty_d = duty_q + 1'b1;
      end
    end
`else
    if (wrap) begin
      duty_d = src_duty;
    end
`endif
    // Gating on the next state drops the enable immediately when leaving RUN/ROTATE.
    pwm_d = active_d && (pwm_cnt_d < duty_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      dir_q        <= ReqStop;
      tgt_q        <= ReqStop;
      tgt_rot_q    <= 1'b0;
      dwell_q      <= '0;
      metal_prev_q <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      pwm_q        <= 1'b0;
      in_q         <= 4'b0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      tgt_q        <= tgt_d;
      tgt_rot_q    <= tgt_rot_d;
      dwell_q      <= dwell_d;
      metal_prev_q <= metal_det;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
      in_q         <= in_d;
      busy_q       <= busy_d;
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign pwm_l = pwm_q;
  assign pwm_r = pwm_q;
  assign in1   = in_q[3];
  assign in2   = in_q[2];
  assign in3   = in_q[1];
  assign in4   = in_q[0];

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: directed vector table, hand sequences and randomized stimulus,
// all checked against a cycle-level reference model of the sequencing rules.
module tb_drive_sequencer;

  localparam int         DW   = 4;
  localparam int         DEAD = 4;
  localparam int         ROT  = 20;
  localparam int         PER  = 16;
  localparam logic [3:0] RD   = 4'd8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fault_l = 1'b0, fault_r = 1'b0, clear = 1'b0, metal_det = 1'b0;
  logic [1:0] track_req = 2'b00;
  logic [3:0] track_duty = 4'd0;
  logic       pwm_l, pwm_r, in1, in2, in3, in4, busy;
  logic [2:0] state;

  drive_sequencer #(
    .DUTY_W       (DW),
    .DEAD_CYCLES  (DEAD),
    .ROTATE_CYCLES(ROT),
    .ROT_DUTY     (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fault_l   (fault_l),
    .fault_r   (fault_r),
    .clear     (clear),
    .metal_det (metal_det),
    .track_req (track_req),
    .track_duty(track_duty),
    .pwm_l     (pwm_l),
    .pwm_r     (pwm_r),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .state     (state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state codes 0..4, target 4 means "rotate".
  int m_state = 0, m_dir = 0, m_tgt = 0, m_dwell = 0, m_pcnt = 0, m_duty = 0;
  bit m_mprev = 1'b0;

  function automatic logic [3:0] dir_bits(input int s, input int d);
    if (s == 3) return 4'b1001;
    if (s != 2) return 4'b0000;
    case (d)
      1:       return 4'b1010;
      2:       return 4'b0110;
      3:       return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_step();
    int  nxt;
    bit  edge_seen;
    int  old_cnt;
    if (rst) begin
      m_state = 0; m_dir = 0; m_tgt = 0; m_dwell = 0; m_pcnt = 0; m_duty = 0; m_mprev = 1'b0;
      return;
    end
    edge_seen = metal_det && !m_mprev;
    m_mprev   = metal_det;
    nxt       = m_state;
    if (fault_l || fault_r) begin
      nxt = 4;
    end else begin
      case (m_state)
        0: begin
          if (edge_seen) begin nxt = 1; m_tgt = 4; end
          else if (track_req != 0) begin nxt = 1; m_tgt = int'(track_req); end
        end
        1: begin
          if (edge_seen) m_tgt = 4;
          else if (m_tgt != 4) m_tgt = int'(track_req);
          if (m_tgt == 0) nxt = 0;
          else if (m_dwell == DEAD - 1) begin
            if (m_tgt == 4) nxt = 3;
            else begin nxt = 2; m_dir = m_tgt; end
          end
        end
        2: begin
          if (edge_seen) begin nxt = 1; m_tgt = 4; end
          else if (track_req == 0) nxt = 0;
          else if (int'(track_req) != m_dir) begin nxt = 1; m_tgt = int'(track_req); end
        end
        3: if (m_dwell == ROT - 1) nxt = 0;
        default: if (clear) nxt = 0;
      endcase
    end
    m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
    old_cnt = m_pcnt;
    m_pcnt  = (m_pcnt + 1) % PER;
    if (old_cnt == PER - 1) begin
      m_duty = (nxt == 2) ? int'(track_duty) : (nxt == 3) ? int'(RD) : 0;
    end
    m_state = nxt;
  endtask

  task automatic model_check();
    logic [9:0] act, exp;
    logic       p;
    p   = ((m_state == 2) || (m_state == 3)) && (m_pcnt < m_duty);
    act = {state, in1, in2, in3, in4, pwm_l, pwm_r, busy};
    exp = {3'(m_state), dir_bits(m_state, m_dir), p, p, (m_state == 1) || (m_state == 3)};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t {state,in,pwm_l,pwm_r,busy} got %b expected %b", $time, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic go_run(input logic [1:0] req);
    int k;
    track_req = req;
    k = 0;
    while (state != 3'd2 && k < 20) begin tick(); k++; end
    check("reach_run", 32'(state), 32'd2);
  endtask

  typedef struct {
    logic       fl, fr, clr, met;
    logic [1:0] req;
    logic [2:0] st;
    logic [3:0] inb;
    logic       bsy;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic fr, input logic clr, input logic met,
                              input logic [1:0] req, input logic [2:0] st,
                              input logic [3:0] inb, input logic bsy);
    vec_t v;
    v.fl = fl; v.fr = fr; v.clr = clr; v.met = met;
    v.req = req; v.st = st; v.inb = inb; v.bsy = bsy;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int highs, k, rot_len;
    // Fields: fault_l fault_r clear metal | track_req -> state in1..in4 busy
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));  // forward request -> DEAD
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd2, 4'b1010, '0));  // RUN forward
    tbl.push_back(mk('0, '0, '0, '0, 2'd2, 3'd1, 4'b0000, '1));  // change to left
    tbl.push_back(mk('0, '0, '0, '0, 2'd2, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd2, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd2, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd2, 3'd2, 4'b0110, '0));  // RUN left
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd0, 4'b0000, '0));  // stop -> IDLE directly
    tbl.push_back(mk('0, '0, '0, '0, 2'd3, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));  // retarget, count kept
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd2, 4'b1010, '0));
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd0, 4'b0000, '0));
    tbl.push_back(mk('0, '0, '0, '0, 2'd2, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd0, 4'b0000, '0));  // stop during DEAD
    tbl.push_back(mk('1, '0, '0, '0, 2'd1, 3'd4, 4'b0000, '0));  // fault wins
    tbl.push_back(mk('1, '0, '1, '0, 2'd1, 3'd4, 4'b0000, '0));  // clear under fault ignored
    tbl.push_back(mk('0, '0, '0, '0, 2'd1, 3'd4, 4'b0000, '0));
    tbl.push_back(mk('0, '0, '1, '0, 2'd0, 3'd0, 4'b0000, '0));
    tbl.push_back(mk('0, '1, '0, '1, 2'd0, 3'd4, 4'b0000, '0));  // fault beats metal edge
    tbl.push_back(mk('0, '0, '1, '0, 2'd0, 3'd0, 4'b0000, '0));
    tbl.push_back(mk('0, '0, '0, '1, 2'd0, 3'd1, 4'b0000, '1));  // metal edge -> DEAD
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd1, 4'b0000, '1));
    tbl.push_back(mk('0, '0, '0, '0, 2'd0, 3'd3, 4'b1001, '1));  // ROTATE

    rst = 1'b1;
    tick();
    tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_in", 32'({in1, in2, in3, in4}), 32'd0);
    check("reset_pwm", 32'({pwm_l, pwm_r}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    track_duty = 4'd12;

    foreach (tbl[i]) begin
      fault_l = tbl[i].fl; fault_r = tbl[i].fr; clear = tbl[i].clr;
      metal_det = tbl[i].met; track_req = tbl[i].req;
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("vec%0d_in", i), 32'({in1, in2, in3, in4}), 32'(tbl[i].inb));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
    end
    clear = 1'b0;

    // ROTATE lasts ROT cycles; a metal pulse inside it is dropped.
    rot_len = 1;
    k = 0;
    while (state == 3'd3 && k < 40) begin
      metal_det = (k == 4);
      tick();
      if (state == 3'd3) rot_len++;
      k++;
    end
    metal_det = 1'b0;
    check("rotate_len", 32'(rot_len), 32'(ROT));
    check("rotate_exit", 32'(state), 32'd0);
    tick();
    check("edge_discarded", 32'(state), 32'd0);

    // PWM duty ratios over a whole period.
    track_duty = 4'd12;
    go_run(2'b01);
    repeat (PER) tick();
    highs = 0;
    for (int c = 0; c < PER; c++) begin tick(); highs += int'(pwm_l); end
    check("pwm_12_of_16", 32'(highs), 32'd12);
    track_duty = 4'd15;
    repeat (PER) tick();
    highs = 0;
    for (int c = 0; c < PER; c++) begin tick(); highs += int'(pwm_r); end
    check("pwm_15_of_16", 32'(highs), 32'd15);
    track_duty = 4'd0;
    repeat (PER) tick();
    highs = 0;
    for (int c = 0; c < PER; c++) begin tick(); highs += int'(pwm_l); end
    check("pwm_0_of_16", 32'(highs), 32'd0);

    // Mid-period duty change waits for count 0.
    track_duty = 4'd12;
    repeat (2 * PER) tick();
    k = 0;
    while (pwm_l == 1'b1 && k < 40) begin tick(); k++; end
    while (pwm_l == 1'b0 && k < 40) begin tick(); k++; end
    check("pwm_phase_found", 32'(k < 40), 32'd1);
    repeat (4) tick();
    track_duty = 4'd2;
    repeat (7) tick();
    check("old_duty_held", 32'(pwm_l), 32'd1);
    repeat (6) tick();
    check("new_duty_high", 32'(pwm_l), 32'd1);
    tick();
    check("new_duty_low", 32'(pwm_l), 32'd0);

    // Metal pulse in RUN, then fault in RUN.
    metal_det = 1'b1;
    tick();
    metal_det = 1'b0;
    check("run_metal_dead", 32'(state), 32'd1);
    k = 0;
    while (state != 3'd0 && k < 60) begin tick(); k++; end
    check("rotate_done", 32'(state), 32'd0);
    track_duty = 4'd9;
    go_run(2'b11);
    fault_l = 1'b1;
    tick();
    check("fault_state", 32'(state), 32'd4);
    check("fault_outputs", 32'({in1, in2, in3, in4, pwm_l, pwm_r}), 32'd0);
    clear = 1'b1;
    tick();
    check("fault_clear_ignored", 32'(state), 32'd4);
    fault_l = 1'b0;
    clear = 1'b0;
    tick();
    check("fault_hold", 32'(state), 32'd4);
    clear = 1'b1;
    track_req = 2'b00;
    tick();
    check("fault_exit", 32'(state), 32'd0);
    clear = 1'b0;

    // Randomized traffic, including occasional mid-run resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) track_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) track_duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) metal_det = ~metal_det;
      fault_l = fault_l ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 199) == 0);
      fault_r = fault_r ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 699) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
